// File: rtl/store_commit_port_pkg.sv
// Shared definitions for the store commit port and its lane-alignment helper.
//   - store subtype encodings (match the ROB's SBOp/SHOp/SWOp)
//   - write-buffer entry layout (word address, lane-aligned data, byte enables)
//   - drain FSM state encoding
package store_commit_port_pkg;

  localparam logic [2:0] SB_OP = 3'b000;
  localparam logic [2:0] SH_OP = 3'b001;
  localparam logic [2:0] SW_OP = 3'b010;

  typedef struct packed {
    logic [29:0] addr;     // word address (byte address bits [31:2])
    logic [31:0] data;     // lane-aligned data, unused lanes zero
    logic [3:0]  byte_en;  // bit i covers data[8i+7:8i]
  } store_entry_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_REQ
  } drain_state_t;

endpackage

// File: rtl/store_commit_port_if.sv
// Signal bundle for the store commit port.
//   ROB side    : cacheWriteEnable/Addr/Data/Type in, cacheWriteDone/storeFault out
//   memory side : memReq/memAddr/memData/memByteEn out, memAck in
//   load side   : loadCheckAddr in, loadConflict/bufferEmpty out
// slave  : the store commit port itself
// master : the environment (ROB, memory and load path)
interface store_commit_port_if;

  logic        cacheWriteEnable;
  logic [31:0] cacheWriteAddr;
  logic [31:0] cacheWriteData;
  logic [2:0]  cacheWriteType;
  logic        cacheWriteDone;
  logic        storeFault;

  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [3:0]  memByteEn;
  logic        memAck;

  logic [31:0] loadCheckAddr;
  logic        loadConflict;
  logic        bufferEmpty;

  modport slave (
    input  cacheWriteEnable, cacheWriteAddr, cacheWriteData, cacheWriteType,
    output cacheWriteDone, storeFault,
    output memReq, memAddr, memData, memByteEn,
    input  memAck,
    input  loadCheckAddr,
    output loadConflict, bufferEmpty
  );

  modport master (
    output cacheWriteEnable, cacheWriteAddr, cacheWriteData, cacheWriteType,
    input  cacheWriteDone, storeFault,
    input  memReq, memAddr, memData, memByteEn,
    output memAck,
    output loadCheckAddr,
    input  loadConflict, bufferEmpty
  );

endinterface

// File: rtl/store_commit_port_lane_align.sv
// store_lane_align: combinational sub-word alignment.
//   addr_lo      in  2   byte offset within the word
//   op           in  3   store subtype (SB/SH/SW)
//   data         in  32  right-justified store data
//   aligned_data out 32  data moved to its byte lanes, unused lanes zero
//   byte_en      out 4   lane enables
//   fault        out 1   misaligned address or unknown subtype
module store_lane_align
  import store_commit_port_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] data,
  output logic [31:0] aligned_data,
  output logic [3:0]  byte_en,
  output logic        fault
);

  always_comb begin
    aligned_data = '0;
    byte_en      = '0;
    fault        = 1'b0;
    case (op)
      SB_OP: begin
        byte_en      = 4'b0001 << addr_lo;
        aligned_data = {24'h0, data[7:0]} << {addr_lo, 3'b000};
      end
      SH_OP: begin
        if (addr_lo[0]) begin
          fault = 1'b1;
        end else if (addr_lo[1]) begin
          byte_en      = 4'b1100;
          aligned_data = {data[15:0], 16'h0};
        end else begin
          byte_en      = 4'b0011;
          aligned_data = {16'h0, data[15:0]};
        end
      end
      SW_OP: begin
        if (addr_lo != 2'b00) begin
          fault = 1'b1;
        end else begin
          byte_en      = '1;
          aligned_data = data;
        end
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_commit_port.sv
// store_commit_port: accepts committed stores from the ROB, aligns them,
// buffers them in a DEPTH-entry FIFO and drains them in order to memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : store_commit_port_if.slave (ROB commit handshake, memory
//                write req/ack, load conflict check, buffer status)
module store_commit_port
  import store_commit_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_commit_port_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  store_entry_t entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_next;
  drain_state_t     state;
  logic             store_fault;

  logic [31:0] aligned_data;
  logic [3:0]  aligned_be;
  logic        align_fault;
  logic        accept, push, pop;

  store_lane_align u_align (
    .addr_lo      (bus.cacheWriteAddr[1:0]),
    .op           (bus.cacheWriteType),
    .data         (bus.cacheWriteData),
    .aligned_data (aligned_data),
    .byte_en      (aligned_be),
    .fault        (align_fault)
  );

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign bus.cacheWriteDone = (count < CNT_DEPTH);
  assign bus.bufferEmpty    = (count == '0);
  assign bus.storeFault     = store_fault;

  assign accept = bus.cacheWriteEnable && bus.cacheWriteDone;
  assign push   = accept && !align_fault;
  assign pop    = (state == DRAIN_REQ) && bus.memAck;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;
  end

  // Storage is only meaningful under count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push)
      entries[tail] <= '{addr: bus.cacheWriteAddr[31:2], data: aligned_data, byte_en: aligned_be};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DRAIN_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      store_fault <= 1'b0;
    end else begin
      store_fault <= accept && align_fault;
      count       <= count_next;
      if (push)
        tail <= tail + PTR_ONE;
      if (pop)
        head <= head + PTR_ONE;
      case (state)
        DRAIN_IDLE: if (count_next != '0) state <= DRAIN_REQ;
        DRAIN_REQ:  if (pop && count_next == '0) state <= DRAIN_IDLE;
        default:    state <= DRAIN_IDLE;
      endcase
    end
  end

  // Payload is the head slot, forced to zero outside REQ so reset and idle
  // show a clean bus; head only moves on a pop, so it is stable until ack.
  assign bus.memReq    = (state == DRAIN_REQ);
  assign bus.memAddr   = bus.memReq ? {entries[head].addr, 2'b00} : '0;
  assign bus.memData   = bus.memReq ? entries[head].data : '0;
  assign bus.memByteEn = bus.memReq ? entries[head].byte_en : '0;

  // Slot i is live when its distance from head is below count.
  logic [PTR_W-1:0] offset;
  logic             conflict;
  always_comb begin
    conflict = 1'b0;
    offset   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head;
      if ({1'b0, offset} < count && entries[i].addr == bus.loadCheckAddr[31:2])
        conflict = 1'b1;
    end
  end
  assign bus.loadConflict = conflict;

endmodule

// File: tb/tb_store_commit_port.sv
module tb_store_commit_port;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  store_commit_port_if bus ();

  store_commit_port #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t q[$];
  logic fault_exp;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference alignment from the store rules: returns 1 when the store is dropped.
  function automatic logic ref_align(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] t, output wr_t w);
    int lo;
    lo = int'(a & 32'd3);
    w.addr = a & ~32'd3;
    w.data = 0;
    w.be   = 0;
    if (t == 3'd0) begin
      w.be   = 4'(1 << lo);
      w.data = (d & 32'hFF) << (8 * lo);
      return 1'b0;
    end
    if (t == 3'd1 && (lo == 0 || lo == 2)) begin
      w.be   = (lo == 2) ? 4'hC : 4'h3;
      w.data = (d & 32'hFFFF) << (8 * lo);
      return 1'b0;
    end
    if (t == 3'd2 && lo == 0) begin
      w.be   = 4'hF;
      w.data = d;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic compare_outputs();
    logic conflict;
    conflict = 1'b0;
    foreach (q[i]) if ((q[i].addr >> 2) == (bus.loadCheckAddr >> 2)) conflict = 1'b1;
    chk("cacheWriteDone", 32'(bus.cacheWriteDone), 32'(q.size() < DEPTH));
    chk("bufferEmpty",    32'(bus.bufferEmpty),    32'(q.size() == 0));
    chk("memReq",         32'(bus.memReq),         32'(q.size() != 0));
    chk("memAddr",        bus.memAddr,             q.size() ? q[0].addr : 32'h0);
    chk("memData",        bus.memData,             q.size() ? q[0].data : 32'h0);
    chk("memByteEn",      32'(bus.memByteEn),      q.size() ? 32'(q[0].be) : 32'h0);
    chk("storeFault",     32'(bus.storeFault),     32'(fault_exp));
    chk("loadConflict",   32'(bus.loadConflict),   32'(conflict));
  endtask

  // One clock: drive at negedge, check just after, advance the model at posedge.
  task automatic cycle(input logic en, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, input logic ack, input logic [31:0] la,
                       output logic acc);
    wr_t  w;
    logic bad;
    @(negedge clk);
    bus.cacheWriteEnable = en;
    bus.cacheWriteAddr   = a;
    bus.cacheWriteData   = d;
    bus.cacheWriteType   = t;
    bus.memAck           = ack;
    bus.loadCheckAddr    = la;
    #1;
    compare_outputs();
    @(posedge clk);
    acc = en && (q.size() < DEPTH);
    bad = ref_align(a, d, t, w);
    if (ack && q.size() != 0) void'(q.pop_front());
    if (acc && !bad) q.push_back(w);
    fault_exp = acc && bad;
  endtask

  task automatic idle(input int n, input logic ack);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 3'd2, ack, 32'hFFFF_FFF0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    n_checks = 0;
    n_fail   = 0;
    fault_exp = 1'b0;
    bus.cacheWriteEnable = 1'b0;
    bus.cacheWriteAddr   = '0;
    bus.cacheWriteData   = '0;
    bus.cacheWriteType   = 3'd2;
    bus.memAck           = 1'b0;
    bus.loadCheckAddr    = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_memReq",  32'(bus.memReq), 32'h0);
    chk("rst_memAddr", bus.memAddr, 32'h0);
    chk("rst_memData", bus.memData, 32'h0);
    chk("rst_memBE",   32'(bus.memByteEn), 32'h0);
    chk("rst_fault",   32'(bus.storeFault), 32'h0);
    chk("rst_done",    32'(bus.cacheWriteDone), 32'h1);
    chk("rst_empty",   32'(bus.bufferEmpty), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SW, acked the cycle after memReq rises
    cycle(1'b1, 32'h1000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b1, 32'h0, acc);
    idle(2, 1'b0);

    // SB then SH into the upper lanes, drained in order
    cycle(1'b1, 32'h1003, 32'h000000AB, 3'd0, 1'b0, 32'h0, acc);
    cycle(1'b1, 32'h1002, 32'h00001234, 3'd1, 1'b0, 32'h0, acc);
    idle(3, 1'b1);

    // Five SWs against a stalled memory: fifth held until a slot frees
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h4000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 3'd2, 1'b0, 32'h0, acc);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h4010, 32'hA0A0_0004, 3'd2, 1'b0, 32'h0, acc);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++)
      cycle(1'b1, 32'h4010, 32'hA0A0_0004, 3'd2, 1'b1, 32'h0, acc);
    chk("fifth_accepted", 32'(acc), 32'h1);
    idle(6, 1'b1);

    // Misaligned SH and SW are dropped with a fault pulse
    cycle(1'b1, 32'h1001, 32'h1111, 3'd1, 1'b1, 32'h0, acc);
    cycle(1'b1, 32'h1002, 32'h2222, 3'd2, 1'b1, 32'h0, acc);
    cycle(1'b1, 32'h1000, 32'h3333, 3'd5, 1'b1, 32'h0, acc);
    idle(3, 1'b1);

    // Load conflict against a pending SW
    cycle(1'b1, 32'h2000, 32'h5555, 3'd2, 1'b0, 32'h2002, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h2002, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h2004, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b1, 32'h2002, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h2002, acc);

    // Randomized traffic over a narrow window so conflicts and hazards occur
    for (int i = 0; i < 600; i++) begin
      logic [2:0] t;
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cycle(1'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 31)), $urandom, t,
            1'($urandom_range(0, 2) != 0), 32'h3000 + 32'($urandom_range(0, 31)), acc);
    end
    idle(6, 1'b1);

    // Reset while a request with three entries is pending
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h6000 + 32'(4 * i), 32'(i + 7), 3'd2, 1'b0, 32'h0, acc);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h0, acc);
    chk("pre_rst_req", 32'(bus.memReq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_memReq", 32'(bus.memReq), 32'h0);
    chk("midrst_done",   32'(bus.cacheWriteDone), 32'h1);
    chk("midrst_empty",  32'(bus.bufferEmpty), 32'h1);
    q.delete();
    fault_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
